// File: rtl/mem_stage.sv
// mem_stage: MIPS-style memory pipeline stage.
// Non-memory instructions pass their EX result to writeback with a latency of
// one cycle. Aligned LW/SW start a data-memory handshake. The stage then holds
// Busy until MemAck arrives or until TIMEOUT cycles pass without it.
// Misaligned accesses and timeouts retire with WE=0 and set the sticky MemErr.
// Ports:
//   CLK, RST (async, active-low)
//   Ins/Result/Rdata2/InValid      : instruction and operands from EX
//   Busy                           : access outstanding, upstream must hold
//   MemReq/MemWE/MemAddr/MemWdata  : data-memory request (registered)
//   MemAck/MemRdata                : data-memory completion
//   OutValid/WE/Wreg/Wdata         : writeback (registered, one-cycle pulse)
//   MemErr                         : sticky misalignment/timeout flag
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic        InValid,
    output logic        Busy,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata,
    output logic        OutValid,
    output logic        WE,
    output logic [4:0]  Wreg,
    output logic [31:0] Wdata,
    output logic        MemErr
);

    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    localparam logic [5:0]  OP_RFORM  = 6'h00;
    localparam logic [5:0]  OP_JAL    = 6'h03;
    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    // Decodes whether an instruction writes the register file (before the r0 override).
    function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        r = 1'b0;
        case (op)
            OP_RFORM: begin
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h09, 6'h10, 6'h12: r = 1'b1;
                    default:             r = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: r = 1'b1;
            OP_LW, OP_JAL:                                   r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      state_r;
    logic        mem_req_r, mem_we_r, out_valid_r, we_r, mem_err_r;
    logic [31:0] mem_addr_r, mem_wdata_r, wdata_r, cnt_r;
    logic [4:0]  wreg_r, acc_wreg_r;
    logic        acc_we_r, acc_load_r;

    logic [5:0]  opcode_s;
    logic [4:0]  wreg_s;
    logic        we_s, is_mem_s, is_sw_s, aligned_s;
    logic [31:0] cnt_inc_s;
    logic        ins_unused_s;

    // The rs and shamt fields play no part in this stage.
    assign ins_unused_s = ^{Ins[25:21], Ins[10:6]};

    // Instruction decode: destination register, write enable, access type.
    always_comb begin
        opcode_s  = Ins[31:26];
        wreg_s    = Ins[20:16];
        is_mem_s  = 1'b0;
        is_sw_s   = 1'b0;
        aligned_s = (Result[1:0] == 2'b00);
        cnt_inc_s = cnt_r + 32'd1;
        if (opcode_s == OP_RFORM) begin
            wreg_s = Ins[15:11];
        end else if (opcode_s == OP_JAL) begin
            wreg_s = 5'd31;
        end else begin
            wreg_s = Ins[20:16];
        end
        if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
            is_mem_s = 1'b1;
            is_sw_s  = (opcode_s == OP_SW);
        end else begin
            is_mem_s = 1'b0;
            is_sw_s  = 1'b0;
        end
        // Writes to r0 are never performed.
        we_s = writes_reg(opcode_s, Ins[5:0]) && (wreg_s != 5'd0);
    end

    // Stage FSM with all registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            out_valid_r <= 1'b0;
            we_r        <= 1'b0;
            wreg_r      <= 5'd0;
            wdata_r     <= 32'd0;
            mem_err_r   <= 1'b0;
            acc_wreg_r  <= 5'd0;
            acc_we_r    <= 1'b0;
            acc_load_r  <= 1'b0;
            cnt_r       <= 32'd0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (InValid) begin
                        if (is_mem_s && aligned_s) begin
                            state_r     <= ACCESS;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= is_sw_s;
                            mem_addr_r  <= Result;
                            mem_wdata_r <= Rdata2;
                            acc_wreg_r  <= wreg_s;
                            acc_we_r    <= we_s;
                            acc_load_r  <= !is_sw_s;
                            cnt_r       <= 32'd0;
                        end else if (is_mem_s) begin
                            // Misaligned: retire without touching memory.
                            out_valid_r <= 1'b1;
                            we_r        <= 1'b0;
                            wreg_r      <= wreg_s;
                            wdata_r     <= Result;
                            mem_err_r   <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b1;
                            we_r        <= we_s;
                            wreg_r      <= wreg_s;
                            wdata_r     <= Result;
                        end
                    end
                end
                ACCESS: begin
                    // An ack takes priority over an expiring timeout.
                    if (MemAck) begin
                        state_r     <= IDLE;
                        mem_req_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        we_r        <= acc_we_r;
                        wreg_r      <= acc_wreg_r;
                        if (acc_load_r) begin
                            wdata_r <= MemRdata;
                        end
                    end else if (cnt_inc_s >= TIMEOUT_C) begin
                        state_r     <= IDLE;
                        mem_req_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        we_r        <= 1'b0;
                        wreg_r      <= acc_wreg_r;
                        mem_err_r   <= 1'b1;
                        cnt_r       <= cnt_inc_s;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = (state_r == ACCESS);
    assign MemReq   = mem_req_r;
    assign MemWE    = mem_we_r;
    assign MemAddr  = mem_addr_r;
    assign MemWdata = mem_wdata_r;
    assign OutValid = out_valid_r;
    assign WE       = we_r;
    assign Wreg     = wreg_r;
    assign Wdata    = wdata_r;
    assign MemErr   = mem_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage (TIMEOUT=4): table of single-cycle instructions plus
// hand-written load/store, misalignment, timeout and reset sequences.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Ins = 32'd0, Result = 32'd0, Rdata2 = 32'd0, MemRdata = 32'd0;
    logic        InValid = 1'b0, MemAck = 1'b0;
    logic        Busy, MemReq, MemWE, OutValid, WE, MemErr;
    logic [31:0] MemAddr, MemWdata, Wdata;
    logic [4:0]  Wreg;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .InValid(InValid), .Busy(Busy), .MemReq(MemReq), .MemWE(MemWE),
        .MemAddr(MemAddr), .MemWdata(MemWdata), .MemAck(MemAck),
        .MemRdata(MemRdata), .OutValid(OutValid), .WE(WE), .Wreg(Wreg),
        .Wdata(Wdata), .MemErr(MemErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic        we;
        logic [4:0]  wreg;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, funct};
    endfunction

    // I-type with immediate 0xA5A5, whose bits [15:11] read as 20.
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd1, rt, 16'hA5A5};
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] rd2);
        Ins = ins; Result = res; Rdata2 = rd2; InValid = 1'b1;
        step();
        InValid = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int req_cnt;
        vecs[0]  = '{r_ins(5'd8,  6'h21), 32'h0000_0005, 1'b1, 5'd8};   // ADDU
        vecs[1]  = '{r_ins(5'd3,  6'h22), 32'hFFFF_FFFF, 1'b1, 5'd3};   // SUB
        vecs[2]  = '{r_ins(5'd4,  6'h18), 32'h0000_1234, 1'b0, 5'd4};   // MULT
        vecs[3]  = '{r_ins(5'd0,  6'h08), 32'h0000_0040, 1'b0, 5'd0};   // JR
        vecs[4]  = '{r_ins(5'd0,  6'h21), 32'h0000_0077, 1'b0, 5'd0};   // ADDU r0
        vecs[5]  = '{i_ins(6'h08, 5'd7),  32'h8000_0000, 1'b1, 5'd7};   // ADDI
        vecs[6]  = '{i_ins(6'h03, 5'd2),  32'h0040_0008, 1'b1, 5'd31};  // JAL
        vecs[7]  = '{i_ins(6'h04, 5'd6),  32'h0000_0001, 1'b0, 5'd6};   // BEQ
        vecs[8]  = '{i_ins(6'h0D, 5'd12), 32'h0000_FFFF, 1'b1, 5'd12};  // ORI
        vecs[9]  = '{i_ins(6'h0B, 5'd13), 32'h0000_0001, 1'b1, 5'd13};  // SLTIU
        vecs[10] = '{i_ins(6'h02, 5'd14), 32'h0000_0100, 1'b0, 5'd14};  // J
        vecs[11] = '{r_ins(5'd17, 6'h12), 32'hABCD_0000, 1'b1, 5'd17};  // MFLO
        vecs[12] = '{i_ins(6'h08, 5'd0),  32'h0000_0009, 1'b0, 5'd0};   // ADDI r0

        // Reset state.
        #12;
        check("rst_busy",   32'(Busy), 32'd0);
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_memwe",  32'(MemWE), 32'd0);
        check("rst_outv",   32'(OutValid), 32'd0);
        check("rst_we",     32'(WE), 32'd0);
        check("rst_memerr", 32'(MemErr), 32'd0);
        check("rst_addr",   MemAddr, 32'd0);
        check("rst_wreg",   32'(Wreg), 32'd0);
        check("rst_wdata",  Wdata, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Table of single-cycle instructions; the first is issued at reset release.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].ins, vecs[i].res, 32'd0);
            check($sformatf("v%0d_outv", i),  32'(OutValid), 32'd1);
            check($sformatf("v%0d_we", i),    32'(WE), 32'(vecs[i].we));
            check($sformatf("v%0d_wreg", i),  32'(Wreg), 32'(vecs[i].wreg));
            check($sformatf("v%0d_wdata", i), Wdata, vecs[i].res);
            check($sformatf("v%0d_memreq", i), 32'(MemReq), 32'd0);
            step();
            check($sformatf("v%0d_pulse", i), 32'(OutValid), 32'd0);
            check($sformatf("v%0d_hold", i),  Wdata, vecs[i].res);
        end

        // MemAck with no request outstanding is ignored.
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        check("stray_ack_outv", 32'(OutValid), 32'd0);
        check("stray_ack_busy", 32'(Busy), 32'd0);

        // LW rt=9 @0x100, ack in the third access cycle.
        issue(i_ins(6'h23, 5'd9), 32'h0000_0100, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 10 && Busy; i++) begin
            busy_cnt++;
            check("lw_req",  32'(MemReq), 32'd1);
            check("lw_addr", MemAddr, 32'h0000_0100);
            check("lw_we",   32'(MemWE), 32'd0);
            if (busy_cnt == 3) begin
                MemAck = 1'b1; MemRdata = 32'hDEAD_BEEF;
            end
            step();
            MemAck = 1'b0; MemRdata = 32'd0;
        end
        check("lw_busy_cycles", 32'(busy_cnt), 32'd3);
        check("lw_outv",  32'(OutValid), 32'd1);
        check("lw_wreg",  32'(Wreg), 32'd9);
        check("lw_wdata", Wdata, 32'hDEAD_BEEF);
        check("lw_wen",   32'(WE), 32'd1);
        check("lw_reqoff", 32'(MemReq), 32'd0);
        step();
        check("lw_pulse", 32'(OutValid), 32'd0);

        // SW @0x104 with immediate ack.
        issue(i_ins(6'h2B, 5'd5), 32'h0000_0104, 32'h1234_5678);
        check("sw_busy",  32'(Busy), 32'd1);
        check("sw_req",   32'(MemReq), 32'd1);
        check("sw_memwe", 32'(MemWE), 32'd1);
        check("sw_addr",  MemAddr, 32'h0000_0104);
        check("sw_wdat",  MemWdata, 32'h1234_5678);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        check("sw_outv", 32'(OutValid), 32'd1);
        check("sw_we",   32'(WE), 32'd0);
        check("sw_busy_after", 32'(Busy), 32'd0);
        check("sw_req_after",  32'(MemReq), 32'd0);
        check("sw_memerr", 32'(MemErr), 32'd0);

        // Ack arriving on the same cycle the timeout would fire.
        issue(i_ins(6'h23, 5'd11), 32'h0000_0200, 32'd0);
        step(); step(); step();
        check("race_req", 32'(MemReq), 32'd1);
        MemAck = 1'b1; MemRdata = 32'hCAFE_0001;
        step();
        MemAck = 1'b0; MemRdata = 32'd0;
        check("race_outv",  32'(OutValid), 32'd1);
        check("race_wdata", Wdata, 32'hCAFE_0001);
        check("race_we",    32'(WE), 32'd1);
        check("race_memerr", 32'(MemErr), 32'd0);

        // Misaligned LW.
        issue(i_ins(6'h23, 5'd9), 32'h0000_0102, 32'd0);
        check("mis_outv",   32'(OutValid), 32'd1);
        check("mis_we",     32'(WE), 32'd0);
        check("mis_memerr", 32'(MemErr), 32'd1);
        check("mis_req",    32'(MemReq), 32'd0);
        check("mis_busy",   32'(Busy), 32'd0);
        issue(r_ins(5'd8, 6'h21), 32'h0000_0005, 32'd0);
        step();
        check("mis_sticky", 32'(MemErr), 32'd1);

        // Timeout with a second LW offered while busy.
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        check("to_memerr_clr", 32'(MemErr), 32'd0);
        issue(i_ins(6'h23, 5'd10), 32'h0000_0300, 32'd0);
        req_cnt = 0;
        for (int i = 0; i < 20 && MemReq; i++) begin
            req_cnt++;
            if (i == 1) begin
                Ins = i_ins(6'h23, 5'd12); Result = 32'h0000_0400; InValid = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            step();
        end
        InValid = 1'b0;
        check("to_req_cycles", 32'(req_cnt), 32'd4);
        check("to_outv",   32'(OutValid), 32'd1);
        check("to_we",     32'(WE), 32'd0);
        check("to_memerr", 32'(MemErr), 32'd1);
        step();
        check("to_pulse",  32'(OutValid), 32'd0);
        check("to_ignored_req",  32'(MemReq), 32'd0);
        check("to_ignored_busy", 32'(Busy), 32'd0);

        // Reset asserted in the second access cycle.
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        issue(i_ins(6'h23, 5'd9), 32'h0000_0100, 32'd0);
        step();
        check("mid_req_before", 32'(MemReq), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("mid_req_async",  32'(MemReq), 32'd0);
        check("mid_busy_async", 32'(Busy), 32'd0);
        @(negedge CLK); RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_outv", 32'(OutValid), 32'd0);
        end
        issue(i_ins(6'h08, 5'd0), 32'h0000_0003, 32'd0);
        check("mid_addi_outv", 32'(OutValid), 32'd1);
        check("mid_addi_we",   32'(WE), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound on the run.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles MemReq may stay pending without MemAck before abort.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low; one clock, no other reset source.
REQ-004 Ins  input  32  instruction leaving EX (opcode Ins[31:26], funct Ins[5:0]).
REQ-005 Result  input  32  EX result: ALU value, or load/store byte address for LW/SW.
REQ-006 Rdata2  input  32  store data (rt value) for SW.
REQ-007 InValid  input  1  Ins/Result/Rdata2 valid this cycle.
REQ-008 Busy  output  1  high while a memory access is outstanding; upstream holds inputs.
REQ-009 MemReq  output  1  data-memory request.
REQ-010 MemWE  output  1  1 = store, 0 = load; qualified by MemReq.
REQ-011 MemAddr  output  32  word-aligned byte address.
REQ-012 MemWdata  output  32  store data.
REQ-013 MemAck  input  1  memory completes request this cycle.
REQ-014 MemRdata  input  32  load data, valid when MemAck=1.
REQ-015 OutValid  output  1  one-cycle pulse: writeback fields valid.
REQ-016 WE  output  1  register-file write enable, qualified by OutValid.
REQ-017 Wreg  output  5  destination register number.
REQ-018 Wdata  output  32  writeback value.
REQ-019 MemErr  output  1  sticky error flag (misaligned or timeout).

Function
REQ-020 States SHALL be IDLE, ACCESS; Busy = (state==ACCESS).
REQ-021 In IDLE with InValid=1 and opcode not LW(0x23)/SW(0x2B): next cycle OutValid=1, Wdata=Result; latency 1.
REQ-022 Wreg SHALL be Ins[15:11] for R_FORM(0x00), 31 for JAL(0x03), Ins[20:16] otherwise.
REQ-023 WE SHALL be 1 for: R_FORM funct ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV/JALR/MFHI/MFLO; ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI; LW; JAL; 0 for all others, and forced 0 when Wreg=0.
REQ-024 In IDLE with InValid=1 and LW/SW and Result[1:0]=0: latch Result, Rdata2, Wreg, opcode; enter ACCESS; MemReq=1 from next cycle.
REQ-025 LW/SW with Result[1:0]!=0: no MemReq; next cycle OutValid=1, WE=0, MemErr set.
REQ-026 In ACCESS, MemReq, MemWE, MemAddr, MemWdata SHALL stay constant until the ack cycle; MemReq=0 outside ACCESS.
REQ-027 MemAck sampled with MemReq=1: next cycle state IDLE, MemReq=0, OutValid=1; LW: Wdata=MemRdata, WE per REQ-023; SW: WE=0.
REQ-028 Minimum load/store latency: InValid edge to OutValid = 2 cycles (ack in first ACCESS cycle).
REQ-029 Cycle counter clears on ACCESS entry, increments each ACCESS cycle without MemAck; when it reaches TIMEOUT: abort, MemReq=0, IDLE, OutValid=1 with WE=0, MemErr set.
REQ-030 MemAck and timeout in the same cycle: MemAck wins, normal completion.
REQ-031 InValid while Busy=1 SHALL be ignored; MemAck while MemReq=0 SHALL be ignored.
REQ-032 OutValid SHALL be a single-cycle pulse per accepted instruction; Wreg/Wdata/WE hold last values when OutValid=0.
REQ-033 MemErr SHALL remain 1 until reset.

Reset
REQ-034 RST=0 SHALL immediately force state IDLE, Busy=0, MemReq=0, MemWE=0, OutValid=0, WE=0, MemErr=0, MemAddr/MemWdata/Wreg/Wdata/counter=0.
REQ-035 RST asserted mid-access SHALL drop MemReq asynchronously; no OutValid for the aborted instruction after release.
REQ-036 First InValid is accepted on the first rising edge with RST=1.

Verification
REQ-037 ADDU rd=8, Result=0x00000005 -> next cycle OutValid=1, WE=1, Wreg=8, Wdata=5, MemReq never high.
REQ-038 LW rt=9, Result=0x100, MemAck 3 cycles after MemReq with MemRdata=0xDEADBEEF -> MemAddr=0x100 stable, Busy 3 cycles, then OutValid=1, Wreg=9, Wdata=0xDEADBEEF.
REQ-039 SW Result=0x104, Rdata2=0x12345678, immediate ack -> MemWE=1, MemWdata=0x12345678, OutValid=1 with WE=0, Busy one cycle.
REQ-040 LW Result=0x102 -> no MemReq, OutValid=1, WE=0, MemErr=1 stays 1.
REQ-041 LW, no MemAck, TIMEOUT=4 -> MemReq high 4 cycles then low, OutValid=1 WE=0, MemErr=1; second LW during Busy ignored.
REQ-042 RST low in ACCESS cycle 2 -> MemReq=0 same cycle, no OutValid after release; ADDI rt=0 afterwards -> OutValid=1, WE=0.
